// File: rtl/decodificador_display_7segmentos.sv
// rtl/decodificador_display_7segmentos.sv - recovers hex digits from a scanned active-low 7-segment bus
// Optional feature macro: DECODIFICADOR_CONTADOR_ERRORES_EN (adds o_Cuenta_errores)
module decodificador_display_7segmentos #(
   parameter int STABLE_CYCLES = 4
) (
   input  logic       i_Reloj,
   input  logic       i_Reset,
   input  logic [6:0] i_Segmentos,
   input  logic [3:0] i_Anodo_4_Bits,
   output logic [3:0] o_Datos_0,
   output logic [3:0] o_Datos_1,
   output logic [3:0] o_Datos_2,
   output logic [3:0] o_Datos_3,
   output logic [3:0] o_Valido_digito,
   output logic       o_Trama_valida,
   output logic       o_Error
`ifdef DECODIFICADOR_CONTADOR_ERRORES_EN
   ,
   output logic [7:0] o_Cuenta_errores
`endif
);

   localparam logic [7:0] UMBRAL = 8'(STABLE_CYCLES - 1);

   typedef enum logic {ESPERA, CAPTURADO} estado_t;

   estado_t         state_q, state_d;
   logic [10:0]     sync1_q, sync2_q;
   logic [7:0]      cnt_q, cnt_d;
   logic [3:0][3:0] datos_q, datos_d;
   logic [3:0]      valid_q, valid_d;
   logic [3:0]      mask_q, mask_d;
   logic            trama_q, trama_d;
   logic            error_q, error_d;

   logic            cambio;
   logic            captura;
   logic [3:0]      anodo;
   logic [6:0]      seg;
   logic [4:0]      glifo;
   logic            uno_frio;
   logic [1:0]      digito;

   // Result bit 4 flags a recognised glyph, bits 3:0 carry its hex value.
   function automatic logic [4:0] decodifica(input logic [6:0] s);
      case (s)
         7'b1000000: return 5'h10;
         7'b1111001: return 5'h11;
         7'b0100100: return 5'h12;
         7'b0110000: return 5'h13;
         7'b0011001: return 5'h14;
         7'b0010010: return 5'h15;
         7'b0000010: return 5'h16;
         7'b1111000: return 5'h17;
         7'b0000000: return 5'h18;
         7'b0010000: return 5'h19;
         7'b0001000: return 5'h1A;
         7'b0000011: return 5'h1B;
         7'b1000110: return 5'h1C;
         7'b0100001: return 5'h1D;
         7'b0000110: return 5'h1E;
         7'b0001110: return 5'h1F;
         default:    return 5'h00;
      endcase
   endfunction

   assign anodo = sync2_q[10:7];
   assign seg   = sync2_q[6:0];
   assign glifo = decodifica(seg);

   always_comb begin
      uno_frio = 1'b1;
      digito   = 2'd0;
      case (anodo)
         4'b1110: digito = 2'd0;
         4'b1101: digito = 2'd1;
         4'b1011: digito = 2'd2;
         4'b0111: digito = 2'd3;
         default: uno_frio = 1'b0;
      endcase
   end

   // sync1 holds the sample that becomes S on the next edge, so a mismatch means S is about to change.
   always_comb begin
      cambio  = (sync1_q != sync2_q);
      captura = (state_q == ESPERA) && (cnt_q == UMBRAL);
      if (cambio)
         cnt_d = 8'd0;
      else if (cnt_q == 8'hFF)
         cnt_d = cnt_q;
      else
         cnt_d = cnt_q + 8'd1;

      state_d = state_q;
      case (state_q)
         ESPERA:    if (captura && !cambio) state_d = CAPTURADO;
         CAPTURADO: if (cambio) state_d = ESPERA;
         default:   state_d = ESPERA;
      endcase
   end

   always_comb begin
      datos_d = datos_q;
      valid_d = valid_q;
      error_d = 1'b0;
      trama_d = (mask_q == 4'hF);
      mask_d  = trama_d ? 4'h0 : mask_q;
      if (captura && (anodo != 4'hF)) begin
         if (uno_frio && glifo[4]) begin
            datos_d[digito] = glifo[3:0];
            valid_d[digito] = 1'b1;
            mask_d[digito]  = 1'b1;
         end else begin
            error_d = 1'b1;
            mask_d  = mask_d & anodo;
         end
      end
   end

   always_ff @(posedge i_Reloj or negedge i_Reset) begin
      if (!i_Reset) begin
         sync1_q <= '1;
         sync2_q <= '1;
         cnt_q   <= 8'd0;
         state_q <= ESPERA;
         datos_q <= '0;
         valid_q <= 4'h0;
         mask_q  <= 4'h0;
         trama_q <= 1'b0;
         error_q <= 1'b0;
      end else begin
         sync1_q <= {i_Anodo_4_Bits, i_Segmentos};
         sync2_q <= sync1_q;
         cnt_q   <= cnt_d;
         state_q <= state_d;
         datos_q <= datos_d;
         valid_q <= valid_d;
         mask_q  <= mask_d;
         trama_q <= trama_d;
         error_q <= error_d;
      end
   end

   assign o_Datos_0       = datos_q[0];
   assign o_Datos_1       = datos_q[1];
   assign o_Datos_2       = datos_q[2];
   assign o_Datos_3       = datos_q[3];
   assign o_Valido_digito = valid_q;
   assign o_Trama_valida  = trama_q;
   assign o_Error         = error_q;

`ifdef DECODIFICADOR_CONTADOR_ERRORES_EN
   logic [7:0] cuenta_q, cuenta_d;

   always_comb begin
      cuenta_d = cuenta_q;
      if (error_d && (cuenta_q != 8'hFF)) cuenta_d = cuenta_q + 8'd1;
   end

   always_ff @(posedge i_Reloj or negedge i_Reset) begin
      if (!i_Reset) cuenta_q <= 8'd0;
      else          cuenta_q <= cuenta_d;
   end

   assign o_Cuenta_errores = cuenta_q;
`endif

endmodule

// File: tb/tb_decodificador_display_7segmentos.sv
// tb/tb_decodificador_display_7segmentos.sv - directed plus randomized bench with an input-history reference model
// Optional feature macro: DECODIFICADOR_CONTADOR_ERRORES_EN (checks o_Cuenta_errores)
module tb_decodificador_display_7segmentos;
   localparam int SC = 4;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [6:0] seg;
   logic [3:0] an;
   logic [3:0] d0, d1, d2, d3, vd;
   logic       tv, er;
`ifdef DECODIFICADOR_CONTADOR_ERRORES_EN
   logic [7:0] ce;
`endif

   decodificador_display_7segmentos #(.STABLE_CYCLES(SC)) dut (
      .i_Reloj(clk),
      .i_Reset(rst_n),
      .i_Segmentos(seg),
      .i_Anodo_4_Bits(an),
      .o_Datos_0(d0),
      .o_Datos_1(d1),
      .o_Datos_2(d2),
      .o_Datos_3(d3),
      .o_Valido_digito(vd),
      .o_Trama_valida(tv),
      .o_Error(er)
`ifdef DECODIFICADOR_CONTADOR_ERRORES_EN
      , .o_Cuenta_errores(ce)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [10:0] hist [0:16383];
   int          ne = 0;
   logic [3:0]  m_datos [4];
   logic [3:0]  m_valid, m_mask;
   logic        m_trama, m_error;
   int          m_cuenta;
   int          tramas;
   logic [6:0]  glifo [16];

   function automatic logic [10:0] h(input int i);
      return (i < 1) ? 11'h7FF : hist[i];
   endfunction

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 4; i++) m_datos[i] = 4'h0;
      m_valid  = 4'h0;
      m_mask   = 4'h0;
      m_trama  = 1'b0;
      m_error  = 1'b0;
      m_cuenta = 0;
   endtask

   // A value is acted on SC+1 edges after it first appears, provided it was held for SC edges.
   task automatic model_edge();
      logic [10:0] v;
      logic        ok;
      int          zeros, k, gi;
      if (!rst_n) begin
         model_reset();
         return;
      end
      m_error = 1'b0;
      m_trama = (m_mask == 4'hF);
      if (m_trama) begin
         m_mask = 4'h0;
         tramas++;
      end
      v  = h(ne - SC - 1);
      ok = (h(ne - SC - 2) != v);
      for (int j = ne - SC; j <= ne - 2; j++) if (h(j) != v) ok = 1'b0;
      if (ok && (v[10:7] != 4'hF)) begin
         zeros = 0;
         k     = 0;
         gi    = -1;
         for (int b = 0; b < 4; b++) if (!v[7+b]) begin zeros++; k = b; end
         for (int g = 0; g < 16; g++) if (glifo[g] == v[6:0]) gi = g;
         if (zeros == 1 && gi >= 0) begin
            m_datos[k] = 4'(gi);
            m_valid[k] = 1'b1;
            m_mask[k]  = 1'b1;
         end else begin
            m_error = 1'b1;
            m_mask  = m_mask & v[10:7];
            if (m_cuenta < 255) m_cuenta++;
         end
      end
   endtask

   task automatic compare_all();
      check("datos0", 8'(d0), 8'(m_datos[0]));
      check("datos1", 8'(d1), 8'(m_datos[1]));
      check("datos2", 8'(d2), 8'(m_datos[2]));
      check("datos3", 8'(d3), 8'(m_datos[3]));
      check("valido", 8'(vd), 8'(m_valid));
      check("trama",  8'(tv), 8'(m_trama));
      check("error",  8'(er), 8'(m_error));
`ifdef DECODIFICADOR_CONTADOR_ERRORES_EN
      check("cuenta", ce, 8'(m_cuenta));
`endif
   endtask

   task automatic cycle(input logic [3:0] a, input logic [6:0] s);
      an = a;
      seg = s;
      hist[ne + 1] = rst_n ? {a, s} : 11'h7FF;
      @(posedge clk);
      ne++;
      model_edge();
      @(negedge clk);
      compare_all();
   endtask

   task automatic hold(input logic [3:0] a, input logic [6:0] s, input int n);
      for (int i = 0; i < n; i++) cycle(a, s);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_d0"}, 8'(d0), 8'h0);
      check({tag, "_d3"}, 8'(d3), 8'h0);
      check({tag, "_vd"}, 8'(vd), 8'h0);
      check({tag, "_tv"}, 8'(tv), 8'h0);
      check({tag, "_er"}, 8'(er), 8'h0);
   endtask

   initial begin
      logic [3:0] ra;
      logic [6:0] rs;
      int         t0;

      glifo = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
      tramas = 0;
      model_reset();
      rst_n = 1'b0;
      an    = 4'hF;
      seg   = 7'h7F;
      @(negedge clk);
      check_all_zero("reset");
      hold(4'hF, 7'h7F, 3);
      rst_n = 1'b1;

      // Digit 0 shows "3": value must appear on the sixth edge, not before.
      hold(4'b1110, 7'b0110000, 5);
      check("d0_before_edge6", 8'(d0), 8'h0);
      cycle(4'b1110, 7'b0110000);
      check("d0_at_edge6", 8'(d0), 8'h3);
      hold(4'b1110, 7'b0110000, 4);
      check("valido_0001", 8'(vd), 8'h1);

      // Full frame 1,A,8,F.
      tramas = 0;
      hold(4'b1110, 7'b1111001, 8);
      hold(4'b1101, 7'b0001000, 8);
      hold(4'b1011, 7'b0000000, 8);
      hold(4'b0111, 7'b0001110, 8);
      hold(4'hF, 7'h7F, 4);
      check("frame_pulses", 8'(tramas), 8'd1);
      check("frame_d1", 8'(d1), 8'hA);
      check("frame_d3", 8'(d3), 8'hF);

      // Blank segments and a two-digit anode are both errors that leave data alone.
      hold(4'b1110, 7'b1111111, 8);
      check("blank_seg_d0", 8'(d0), 8'h1);
      hold(4'b1100, 7'b1000000, 8);
      check("multi_anode_d0", 8'(d0), 8'h1);
      check("multi_anode_vd", 8'(vd), 8'hF);

      // Toggling faster than the window never captures; then reset mid-window.
      for (int i = 0; i < 6; i++) hold(4'b1110, (i % 2 == 1) ? 7'b1000000 : 7'b0100100, 3);
      hold(4'b1101, 7'b0110000, 2);
      #2 rst_n = 1'b0;
      #1 model_reset();
      check_all_zero("async_reset");
      hold(4'b1101, 7'b0110000, 2);
      rst_n = 1'b1;
      hold(4'b1101, 7'b0011001, 8);
      check("post_reset_d1", 8'(d1), 8'h4);

      // Randomized runs of varying length over anodes and glyphs.
      for (int i = 0; i < 300; i++) begin
         case ($urandom_range(0, 5))
            0: ra = 4'b1110;
            1: ra = 4'b1101;
            2: ra = 4'b1011;
            3: ra = 4'b0111;
            4: ra = 4'b1111;
            default: ra = 4'($urandom);
         endcase
         if ($urandom_range(0, 9) < 8) rs = glifo[$urandom_range(0, 15)];
         else                          rs = 7'($urandom);
         hold(ra, rs, $urandom_range(1, 10));
      end

`ifdef DECODIFICADOR_CONTADOR_ERRORES_EN
      t0 = m_cuenta;
      for (int i = 0; i < 300; i++) hold(4'b1110, (i % 2 == 1) ? 7'b1111110 : 7'b1111111, 5);
      check("cuenta_saturada", ce, 8'd255);
`else
      t0 = 0;
`endif
      if (t0 < 0) $display("unexpected counter start %0d", t0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
